// File: rtl/bcd_count_ctrl_pkg.sv
// rtl/bcd_count_ctrl_pkg.sv - shared constants for the BCD count controller
//
// Holds the command op-codes, the FSM state encoding, the BCD digit width
// and a nibble-validity helper. Imported by bcd_digit and bcd_count_ctrl.
// Optional feature macro used by the importing files: BCD_COUNT_CTRL_DOWN_EN.

package bcd_count_ctrl_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] OP_CLEAR     = 2'd0;
    localparam logic [1:0] OP_START     = 2'd1;
    localparam logic [1:0] OP_PAUSE     = 2'd2;
    localparam logic [1:0] OP_SET_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic nibble_is_bcd(input logic [BCD_W-1:0] n);
        return n <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_bcd_digit.sv
// rtl/bcd_count_ctrl_bcd_digit.sv - one BCD digit with carry chain and load
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset (q -> 0)
//   en              global step enable for this cycle
//   down            count direction, 1 = decrement (BCD_COUNT_CTRL_DOWN_EN only)
//   cin             carry/borrow in; the digit steps when en & cin
//   load, load_val  synchronous load, wins over stepping
//   q               digit value, always 0..9
//   cout            carry/borrow out, combinational (cin & digit wraps)

module bcd_digit
    import bcd_count_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef BCD_COUNT_CTRL_DOWN_EN
    input  logic             down,
`endif
    input  logic             cin,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic wrap;

`ifdef BCD_COUNT_CTRL_DOWN_EN
    assign wrap = down ? (q == 4'd0) : (q == 4'd9);
`else
    assign wrap = (q == 4'd9);
`endif

    assign cout = cin & wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en && cin) begin
`ifdef BCD_COUNT_CTRL_DOWN_EN
            if (down)
                q <= wrap ? 4'd9 : q - 4'd1;
            else
                q <= wrap ? 4'd0 : q + 4'd1;
`else
            q <= wrap ? 4'd0 : q + 4'd1;
`endif
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - command-driven multi-digit BCD counter controller
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready is low only in LOAD
//   cmd_op, cmd_data    CLEAR / START / PAUSE / SET_LIMIT, BCD limit value
//   tick                count enable, one step per high cycle while in RUN
//   dir                 0 up, 1 down (only with BCD_COUNT_CTRL_DOWN_EN)
//   count               current BCD count
//   running             high in RUN
//   tc                  one-cycle terminal-count pulse
//   cmd_err             one-cycle pulse for a rejected SET_LIMIT
//   state               FSM state encoding for debug
// Optional feature macro: BCD_COUNT_CTRL_DOWN_EN (adds dir and down counting).

module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [BCD_W*DIGITS-1:0] cmd_data,
    input  logic                  tick,
`ifdef BCD_COUNT_CTRL_DOWN_EN
    input  logic                  dir,
`endif
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                  running,
    output logic                  tc,
    output logic                  cmd_err,
    output logic [2:0]            state
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_LOAD  = 3'(ST_LOAD);
    localparam logic [2:0] S_RUN   = 3'(ST_RUN);
    localparam logic [2:0] S_PAUSE = 3'(ST_PAUSE);
    localparam logic [2:0] S_DONE  = 3'(ST_DONE);

    logic [2:0]   st;
    logic [W-1:0] limit;

    logic         cmd_acc;
    logic         data_ok;
    logic         count_tick;
    logic         at_term;
    logic [W-1:0] reload_val;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         cnt_step;
    logic [DIGITS:0] carry;
    logic         carry_unused;

    assign state     = st;
    assign cmd_ready = (st != S_LOAD);
    assign running   = (st == S_RUN);
    assign cmd_acc   = cmd_valid & cmd_ready;

    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!nibble_is_bcd(cmd_data[i*BCD_W +: BCD_W]))
                data_ok = 1'b0;
        end
    end

    // An accepted command in the same cycle swallows the tick.
    assign count_tick = (st == S_RUN) & tick & ~cmd_acc;

`ifdef BCD_COUNT_CTRL_DOWN_EN
    assign at_term    = dir ? (count == '0) : (count == limit);
    assign reload_val = dir ? limit : '0;
`else
    assign at_term    = (count == limit);
    assign reload_val = '0;
`endif

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        if (cmd_acc) begin
            case (cmd_op)
                OP_CLEAR: begin
                    cnt_load = 1'b1;
                end
                OP_START: begin
                    if (st == S_DONE) begin
                        cnt_load = 1'b1;
`ifdef BCD_COUNT_CTRL_DOWN_EN
                        cnt_load_val = dir ? limit : '0;
`endif
                    end
                end
                OP_SET_LIMIT: begin
                    if (data_ok && st != S_RUN)
                        cnt_load = 1'b1;
                end
                default: ;
            endcase
        end else if (count_tick && at_term) begin
            cnt_load     = 1'b1;
            cnt_load_val = reload_val;
        end
    end

    assign cnt_step = count_tick & ~at_term;

    // Ripple carry is combinational; every digit updates on the same edge.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .en       (cnt_step),
`ifdef BCD_COUNT_CTRL_DOWN_EN
            .down     (dir),
`endif
            .cin      (carry[g]),
            .load     (cnt_load),
            .load_val (cnt_load_val[g*BCD_W +: BCD_W]),
            .q        (count[g*BCD_W +: BCD_W]),
            .cout     (carry[g+1])
        );
    end

    // The top digit's carry has no consumer: terminal count always fires
    // before the counter could wrap past its widest value.
    assign carry_unused = carry[DIGITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= S_IDLE;
            limit   <= ALL_NINES;
            tc      <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            tc      <= 1'b0;
            cmd_err <= 1'b0;
            if (cmd_acc) begin
                case (cmd_op)
                    OP_CLEAR: st <= S_IDLE;
                    OP_START: begin
                        if (st != S_RUN)
                            st <= S_RUN;
                    end
                    OP_PAUSE: begin
                        if (st == S_RUN)
                            st <= S_PAUSE;
                    end
                    OP_SET_LIMIT: begin
                        if (!data_ok || st == S_RUN) begin
                            cmd_err <= 1'b1;
                        end else begin
                            limit <= cmd_data;
                            st    <= S_LOAD;
                        end
                    end
                    default: ;
                endcase
            end else if (st == S_LOAD) begin
                st <= S_IDLE;
            end else if (count_tick && at_term) begin
                tc <= 1'b1;
                if (!AUTO_RELOAD)
                    st <= S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - self-checking bench for bcd_count_ctrl (AUTO_RELOAD 1 and 0)

module tb_bcd_count_ctrl;

    localparam logic [1:0] CLR = 2'd0, STA = 2'd1, PAU = 2'd2, SET = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        tick = 1'b0;
`ifdef BCD_COUNT_CTRL_DOWN_EN
    logic        dir = 1'b0;
`endif

    logic        rdy_a, run_a, tc_a, err_a;
    logic [15:0] cnt_a;
    logic [2:0]  st_a;
    logic        rdy_b, run_b, tc_b, err_b;
    logic [15:0] cnt_b;
    logic [2:0]  st_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.DIGITS(4), .AUTO_RELOAD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_a),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick),
`ifdef BCD_COUNT_CTRL_DOWN_EN
        .dir(dir),
`endif
        .count(cnt_a), .running(run_a), .tc(tc_a), .cmd_err(err_a), .state(st_a)
    );

    bcd_count_ctrl #(.DIGITS(4), .AUTO_RELOAD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy_b),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .tick(tick),
`ifdef BCD_COUNT_CTRL_DOWN_EN
        .dir(dir),
`endif
        .count(cnt_b), .running(run_b), .tc(tc_b), .cmd_err(err_b), .state(st_b)
    );

    typedef struct {
        logic        sel;   // 0 checks dut_a (auto-reload), 1 checks dut_b (halt)
        logic        v;
        logic [1:0]  op;
        logic [15:0] d;
        logic        t;
        logic [15:0] c;
        logic [2:0]  s;
        logic        tc;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic sel, input logic v, input logic [1:0] op,
                                input logic [15:0] d, input logic t, input logic [15:0] c,
                                input logic [2:0] s, input logic tcx, input logic err,
                                input logic rdy);
        vec_t e;
        e.sel = sel; e.v = v; e.op = op; e.d = d; e.t = t;
        e.c = c; e.s = s; e.tc = tcx; e.err = err; e.rdy = rdy;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] d, input logic t);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick      = t;
        cyc();
        cmd_valid = 1'b0;
        tick      = 1'b0;
    endtask

    task automatic ticks(input int n, output int tcs);
        tcs  = 0;
        tick = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (tc_a) tcs++;
        end
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        vec_t v;
        int   n_tc;

        // Section 1, dut_a: limit 0x0012, 13 ticks, wrap with one tc, stays RUN
        add(0, 1, SET, 16'h0012, 0, 16'h0000, 3'd1, 0, 0, 0);
        add(0, 0, CLR, 16'h0000, 0, 16'h0000, 3'd0, 0, 0, 1);
        add(0, 1, STA, 16'h0000, 0, 16'h0000, 3'd2, 0, 0, 1);
        for (int i = 1; i <= 12; i++)
            add(0, 0, CLR, 16'h0, 1, 16'(((i / 10) << 4) | (i % 10)), 3'd2, 0, 0, 1);
        add(0, 0, CLR, 16'h0000, 1, 16'h0000, 3'd2, 1, 0, 1);
        // Section 2, dut_b: limit 3, halt in DONE, ticks ignored, START resumes
        add(1, 1, CLR, 16'h0000, 0, 16'h0000, 3'd0, 0, 0, 1);
        add(1, 1, SET, 16'h0003, 0, 16'h0000, 3'd1, 0, 0, 0);
        add(1, 0, CLR, 16'h0000, 0, 16'h0000, 3'd0, 0, 0, 1);
        add(1, 1, STA, 16'h0000, 0, 16'h0000, 3'd2, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0001, 3'd2, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0002, 3'd2, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0003, 3'd2, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0000, 3'd4, 1, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0000, 3'd4, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0000, 3'd4, 0, 0, 1);
        add(1, 1, STA, 16'h0000, 0, 16'h0000, 3'd2, 0, 0, 1);
        add(1, 0, CLR, 16'h0000, 1, 16'h0001, 3'd2, 0, 0, 1);

        // Reset values, checked while rst is held low
        rst = 1'b0;
        cyc();
        chk("reset count", cnt_a, 16'h0);
        chk("reset state", st_a, 3'd0);
        chk("reset tc", tc_a, 1'b0);
        chk("reset err", err_a, 1'b0);
        chk("reset running", run_a, 1'b0);
        chk("reset ready", rdy_a, 1'b1);
        rst = 1'b1;
        cyc();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cmd_valid = v.v;
            cmd_op    = v.op;
            cmd_data  = v.d;
            tick      = v.t;
            cyc();
            if (v.sel) begin
                chk($sformatf("vec%0d count", i), cnt_b, v.c);
                chk($sformatf("vec%0d state", i), st_b, v.s);
                chk($sformatf("vec%0d tc", i), tc_b, v.tc);
                chk($sformatf("vec%0d err", i), err_b, v.err);
                chk($sformatf("vec%0d ready", i), rdy_b, v.rdy);
            end else begin
                chk($sformatf("vec%0d count", i), cnt_a, v.c);
                chk($sformatf("vec%0d state", i), st_a, v.s);
                chk($sformatf("vec%0d tc", i), tc_a, v.tc);
                chk($sformatf("vec%0d err", i), err_a, v.err);
                chk($sformatf("vec%0d ready", i), rdy_a, v.rdy);
            end
        end
        cmd_valid = 1'b0;
        tick      = 1'b0;

        // Carry ripple across all digits, and wrap at 9999
        do_reset();
        cmd(STA, 16'h0, 0);
        ticks(999, n_tc);
        chk("ripple 0999", cnt_a, 16'h0999);
        ticks(1, n_tc);
        chk("ripple 1000", cnt_a, 16'h1000);
        chk("ripple 1000 tc", tc_a, 1'b0);
        ticks(8999, n_tc);
        chk("ripple 9999", cnt_a, 16'h9999);
        chk("ripple no early tc", n_tc, 0);
        ticks(1, n_tc);
        chk("wrap count", cnt_a, 16'h0000);
        chk("wrap tc", tc_a, 1'b1);

        // Rejected SET_LIMIT: non-BCD data and while running
        do_reset();
        cmd(SET, 16'h0002, 0);
        chk("set ready low", rdy_a, 1'b0);
        cyc();
        chk("set ready back", rdy_a, 1'b1);
        cmd(SET, 16'h00A5, 0);
        chk("bad bcd err", err_a, 1'b1);
        chk("bad bcd state", st_a, 3'd0);
        cyc();
        chk("bad bcd err pulse", err_a, 1'b0);
        cmd(STA, 16'h0, 0);
        ticks(2, n_tc);
        chk("limit2 count", cnt_a, 16'h0002);
        cmd(SET, 16'h0005, 0);
        chk("run set err", err_a, 1'b1);
        chk("run set state", st_a, 3'd2);
        cyc();
        chk("run set err pulse", err_a, 1'b0);
        ticks(1, n_tc);
        chk("limit kept count", cnt_a, 16'h0000);
        chk("limit kept tc", tc_a, 1'b1);
        // limit 0: every tick is a terminal count
        cmd(PAU, 16'h0, 0);
        cmd(SET, 16'h0000, 0);
        chk("limit0 load", st_a, 3'd1);
        cyc();
        cmd(STA, 16'h0, 0);
        ticks(3, n_tc);
        chk("limit0 tc per tick", n_tc, 3);
        chk("limit0 count", cnt_a, 16'h0000);

        // PAUSE together with tick: command wins, tick dropped
        do_reset();
        cmd(STA, 16'h0, 0);
        ticks(7, n_tc);
        chk("pre-pause count", cnt_a, 16'h0007);
        cmd(PAU, 16'h0, 1);
        chk("pause state", st_a, 3'd3);
        chk("pause count", cnt_a, 16'h0007);
        chk("pause tc", tc_a, 1'b0);
        ticks(2, n_tc);
        chk("paused ticks ignored", cnt_a, 16'h0007);
        cmd(STA, 16'h0, 0);
        chk("resume state", st_a, 3'd2);
        ticks(1, n_tc);
        chk("resume count", cnt_a, 16'h0008);

        // Asynchronous reset in the middle of a run
        do_reset();
        cmd(SET, 16'h0500, 0);
        cyc();
        cmd(STA, 16'h0, 0);
        ticks(456, n_tc);
        chk("pre-reset count", cnt_a, 16'h0456);
        tick = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst count", cnt_a, 16'h0000);
        chk("async rst state", st_a, 3'd0);
        chk("async rst running", run_a, 1'b0);
        tick = 1'b0;
        cyc();
        chk("async rst tc", tc_a, 1'b0);
        rst = 1'b1;
        cyc();
        cmd(STA, 16'h0, 0);
        ticks(501, n_tc);
        chk("limit reset to 9999", cnt_a, 16'h0501);
        chk("limit reset no tc", n_tc, 0);

`ifdef BCD_COUNT_CTRL_DOWN_EN
        // Down counting from limit 2 with reload
        do_reset();
        dir = 1'b1;
        cmd(SET, 16'h0002, 0);
        cyc();
        cmd(STA, 16'h0, 0);
        ticks(1, n_tc);
        chk("down reload a", cnt_a, 16'h0002);
        chk("down reload a tc", tc_a, 1'b1);
        ticks(1, n_tc);
        chk("down 1", cnt_a, 16'h0001);
        ticks(1, n_tc);
        chk("down 0", cnt_a, 16'h0000);
        chk("down 0 tc", tc_a, 1'b0);
        ticks(1, n_tc);
        chk("down reload b", cnt_a, 16'h0002);
        chk("down reload b tc", tc_a, 1'b1);
        dir = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
